// File: rtl/booth_mul4.sv
// Sequential radix-2 Booth multiplier, signed N x N -> 2N, one Booth step per cycle.
// Latency N cycles from the start edge to done; start is ignored while busy. Define BOOTH_MUL_FLAGS_EN to add the Z/V flag outputs.
module booth_mul4 #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic [2*N-1:0] P,
    output logic           busy,
`ifdef BOOTH_MUL_FLAGS_EN
    output logic           Z,
    output logic           V,
`endif
    output logic           done
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(N);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [N:0]     ac_q, ac_d;
    logic [N-1:0]   q_q, q_d;
    logic           q1_q, q1_d;
    logic [N:0]     mr_q, mr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] p_q, p_d;
    logic           z_q, z_d;
    logic           v_q, v_d;

    logic           sub;
    logic [N:0]     sum;
    logic [N:0]     ac_sel;
    logic [N:0]     ac_n;
    logic [N-1:0]   q_n;
    logic [2*N-1:0] prod;
    logic [N:0]     prod_top;

    // Add/subtract datapath: subtract is MR inverted with carry-in 1.
    always_comb begin
        sub    = q_q[0] & ~q1_q;
        sum    = ac_q + (mr_q ^ {(N+1){sub}}) + {{N{1'b0}}, sub};
        ac_sel = (q_q[0] ^ q1_q) ? sum : ac_q;
        ac_n   = {ac_sel[N], ac_sel[N:1]};
        q_n    = {ac_sel[0], q_q[N-1:1]};
        prod   = {ac_n[N-1:0], q_n};
        prod_top = prod[2*N-1:N-1];
    end

    always_comb begin
        state_d = state_q;
        ac_d    = ac_q;
        q_d     = q_q;
        q1_d    = q1_q;
        mr_d    = mr_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        z_d     = z_q;
        v_d     = v_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    ac_d    = '0;
                    q_d     = B;
                    q1_d    = 1'b0;
                    mr_d    = {A[N-1], A};
                    cnt_d   = CNT_LOAD;
                    state_d = ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                ac_d  = ac_n;
                q_d   = q_n;
                q1_d  = q_q[0];
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    p_d     = prod;
                    z_d     = (prod == '0);
                    v_d     = ~((&prod_top) | ~(|prod_top));
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ac_q    <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            mr_q    <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            z_q     <= 1'b1;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            ac_q    <= ac_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            mr_q    <= mr_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            z_q     <= z_d;
            v_q     <= v_d;
        end
    end

    assign P    = p_q;
    assign busy = (state_q == ST_CALC);
    assign done = (state_q == ST_DONE);
`ifdef BOOTH_MUL_FLAGS_EN
    assign Z = z_q;
    assign V = v_q;
`else
    logic unused_flags;
    assign unused_flags = z_q ^ v_q;
`endif

endmodule
